posit_accum_seq: RTL and testbench



---
 rtl/posit_accum_seq_pkg.sv | 20 ++
 rtl/posit_accum_seq_counter.sv | 27 ++
 rtl/posit_accum_seq.sv | 136 +++++++++++++
 tb/tb_posit_accum_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_accum_seq_pkg.sv
// Shared definitions for the ES2 serialized-posit accumulator and its batch sequencer.
// Serialized layout: {sgn, scale[7:0], fraction[26:0], inf, zero}.
package posit_defines;

  localparam int POSIT_SERIALIZED_WIDTH_ES2       = 38;
  localparam int POSIT_SERIALIZED_WIDTH_ACCUM_ES2 = 38;
  localparam int ACCUM_LOOP_LAT_ES2               = 17;

  typedef enum logic [1:0] {
    CLEAR,
    ISSUE,
    WAIT,
    OUTPUT
  } accum_seq_state_t;

  function automatic logic posit_is_zero(input logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] p);
    return p[0];
  endfunction

endpackage

// File: rtl/posit_accum_seq_counter.sv
// Loadable saturating down-counter; o_expire flags the last counted cycle (count <= 1).
module accum_wait_counter #(
  parameter int W       = 5,
  parameter int RST_VAL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= W'(RST_VAL);
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count <= W'(1));

endmodule

// File: rtl/posit_accum_seq.sv
// Batch sequencer for positaccum_16_raw: paces operand issue to the feedback loop latency.
// Optional build macro POSIT_ACCUM_SEQ_SKIP_ZERO_EN: zero operands are counted but not issued.
module posit_accum_seq
  import posit_defines::*;
#(
  parameter int LOOP_LAT   = ACCUM_LOOP_LAT_ES2,
  parameter int CLR_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        s_valid,
  output logic                                        s_ready,
  input  logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]       s_data,
  input  logic                                        s_last,
  output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]       acc_in1,
  output logic                                        acc_start,
  output logic                                        acc_clr,
  input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] acc_result,
  input  logic                                        acc_done,
  output logic                                        m_valid,
  input  logic                                        m_ready,
  output logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] m_data,
  output logic [CNT_W-1:0]                            m_count
);

  localparam int CW = $clog2(((LOOP_LAT > CLR_CYCLES) ? LOOP_LAT : CLR_CYCLES) + 1);

  accum_seq_state_t r_state, w_state_next;

  logic                                        r_last;
  logic                                        r_acc_start;
  logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]       r_acc_in1;
  logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] r_m_data;
  logic [CNT_W-1:0]                            r_m_count;

  logic            w_skip;
  logic            w_accept;
  logic            w_issue;
  logic            w_expire;
  logic            w_cnt_load;
  logic [CW-1:0]   w_cnt_load_val;

`ifdef POSIT_ACCUM_SEQ_SKIP_ZERO_EN
  assign w_skip = posit_is_zero(s_data);
`else
  assign w_skip = 1'b0;
`endif

  assign w_accept = (r_state == ISSUE) && s_valid;
  assign w_issue  = w_accept && !w_skip;

  // One counter serves both countdowns: issue spacing in WAIT, clear length in CLEAR.
  assign w_cnt_load     = w_issue || ((r_state == OUTPUT) && m_ready);
  assign w_cnt_load_val = (r_state == ISSUE) ? CW'(LOOP_LAT - 1) : CW'(CLR_CYCLES);

  accum_wait_counter #(
    .W       (CW),
    .RST_VAL (CLR_CYCLES)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (w_expire) w_state_next = ISSUE;
      ISSUE: begin
        if (w_issue) begin
          w_state_next = WAIT;
        end else if (w_accept && s_last) begin
          w_state_next = OUTPUT;
        end
      end
      // The last operand waits for its own sum; earlier ones only wait out the loop latency.
      WAIT: begin
        if (r_last) begin
          if (acc_done) w_state_next = OUTPUT;
        end else if (w_expire) begin
          w_state_next = ISSUE;
        end
      end
      OUTPUT:  if (m_ready) w_state_next = CLEAR;
      default: w_state_next = CLEAR;
    endcase
  end

  always_comb begin
    s_ready = (r_state == ISSUE);
    acc_clr = (r_state == CLEAR);
    m_valid = (r_state == OUTPUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= 1'b0;
      r_acc_start <= 1'b0;
      r_acc_in1   <= '0;
      r_m_data    <= '0;
      r_m_count   <= '0;
    end else begin
      r_acc_start <= w_issue;
      if (w_issue) begin
        r_acc_in1 <= s_data;
      end
      if (w_accept) begin
        r_last <= s_last;
        if (r_m_count != '1) r_m_count <= r_m_count + 1'b1;
      end
      if ((w_accept && w_skip && s_last) || ((r_state == WAIT) && r_last && acc_done)) begin
        r_m_data <= acc_result;
      end
      if ((r_state == OUTPUT) && m_ready) begin
        r_m_count <= '0;
      end
    end
  end

  assign acc_start = r_acc_start;
  assign acc_in1   = r_acc_in1;
  assign m_data    = r_m_data;
  assign m_count   = r_m_count;

endmodule

// File: tb/tb_posit_accum_seq.sv
// Self-checking bench for posit_accum_seq with a behavioural accumulator and real-valued reference sums.
module tb_posit_accum_seq;
  import posit_defines::*;

  localparam int LOOP_LAT   = 17;
  localparam int CLR_CYCLES = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int ACC_LAT    = 8;
  localparam int W          = POSIT_SERIALIZED_WIDTH_ES2;
`ifdef POSIT_ACCUM_SEQ_SKIP_ZERO_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready, s_last;
  logic [W-1:0] s_data, acc_in1, acc_result, m_data;
  logic         acc_start, acc_clr, acc_done, m_valid, m_ready;
  logic [CNT_W-1:0] m_count;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  real vals[32];

  posit_accum_seq #(
    .LOOP_LAT   (LOOP_LAT),
    .CLR_CYCLES (CLR_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .acc_in1    (acc_in1),
    .acc_start  (acc_start),
    .acc_clr    (acc_clr),
    .acc_result (acc_result),
    .acc_done   (acc_done),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_count    (m_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] enc(input real v);
    logic [W-1:0] r;
    int     s;
    real    m;
    longint f;
    r = '0;
    if (v == 0.0) begin
      r[0] = 1'b1;
      return r;
    end
    m = v;
    s = 0;
    while (m >= 2.0) begin m = m / 2.0; s++; end
    while (m < 1.0) begin m = m * 2.0; s--; end
    f = longint'((m - 1.0) * 134217728.0);
    r[36:29] = s[7:0];
    r[28:2]  = f[26:0];
    return r;
  endfunction

  function automatic real dec(input logic [W-1:0] p);
    real m;
    int  s;
    if (p[0]) return 0.0;
    m = 1.0 + real'(p[28:2]) / 134217728.0;
    s = int'($signed(p[36:29]));
    while (s > 0) begin m = m * 2.0; s--; end
    while (s < 0) begin m = m / 2.0; s++; end
    return m;
  endfunction

  // Accumulator model: clears on acc_clr, adds in1 ACC_LAT cycles after start, pulses done.
  real acc_sum;
  real pend_val;
  int  pend_cnt;
  always @(posedge clk) begin
    acc_done <= 1'b0;
    if (acc_clr) begin
      acc_sum    <= 0.0;
      acc_result <= enc(0.0);
      pend_cnt   <= 0;
    end else if (acc_start) begin
      pend_val <= dec(acc_in1);
      pend_cnt <= ACC_LAT;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) begin
        acc_sum    <= acc_sum + pend_val;
        acc_result <= enc(acc_sum + pend_val);
        acc_done   <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_s_ready",   s_ready,   0);
    check("rst_acc_in1",   acc_in1,   0);
    check("rst_acc_start", acc_start, 0);
    check("rst_acc_clr",   acc_clr,   1);
    check("rst_m_valid",   m_valid,   0);
    check("rst_m_data",    m_data,    0);
    check("rst_m_count",   m_count,   0);
  endtask

  task automatic run_batch(input int id, input int n, input int gap_max, input int hold);
    real          sum;
    int           last_hs;
    bit           prev_issued;
    bit           is_skip;
    int           w;
    int           exp_cnt;
    logic [W-1:0] exp_data;
    sum = 0.0;
    last_hs = 0;
    prev_issued = 1'b0;
    is_skip = 1'b0;
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) tick();
      s_data  = enc(vals[i]);
      s_last  = (i == n - 1);
      s_valid = 1'b1;
      w = 0;
      while (!s_ready && w < 100) begin tick(); w++; end
      check("s_ready_timeout", s_ready, 1);
      if (gap == 0 && i > 0) check("issue_spacing", cyc - last_hs, prev_issued ? LOOP_LAT : 1);
      last_hs = cyc;
      sum = sum + vals[i];
      is_skip = SKIP_EN && (vals[i] == 0.0);
      tick();
      s_valid = 1'b0;
      if (!is_skip) begin
        check("acc_start", acc_start, 1);
        check("acc_in1", acc_in1, enc(vals[i]));
        check("s_ready_in_wait", s_ready, 0);
        prev_issued = 1'b1;
      end else begin
        check("skip_no_start", acc_start, 0);
        if (i < n - 1) check("skip_ready_next", s_ready, 1);
        prev_issued = 1'b0;
      end
    end
    if (!is_skip) begin
      w = 0;
      while (!acc_done && w < 100) begin tick(); w++; end
      check("done_timeout", acc_done, 1);
      check("m_valid_early", m_valid, 0);
      tick();
    end
    exp_data = enc(sum);
    exp_cnt  = (n > CNT_MAX) ? CNT_MAX : n;
    check("m_valid", m_valid, 1);
    check("m_data", m_data, exp_data);
    check("m_count", m_count, exp_cnt);
    $display("batch %0d: beats=%0d sum=%0.3f m_data=%0h m_count=%0d", id, n, sum, m_data, m_count);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("output_hold", {m_valid, s_ready, m_data, m_count}, {1'b1, 1'b0, exp_data, CNT_W'(exp_cnt)});
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("m_count_cleared", m_count, 0);
    for (int c = 0; c < CLR_CYCLES; c++) begin
      check("clear_phase", {acc_clr, s_ready, m_valid}, 3'b100);
      tick();
    end
    check("ready_after_clear", {acc_clr, s_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    #1;
    tick();
    tick();
    check_reset_values();
    rst = 1'b0;

    vals[0] = 1.0;
    run_batch(0, 1, 0, 0);

    vals[0] = 1.5; vals[1] = 1.5;
    run_batch(1, 2, 0, 30);

    // Abort a batch five cycles into WAIT and make sure nothing of it survives.
    s_data = enc(1.5); s_last = 1'b0; s_valid = 1'b1;
    for (int w = 0; w < 100 && !s_ready; w++) tick();
    check("abort_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check_reset_values();
    tick();
    rst = 1'b0;
    $display("reset applied mid-batch at cycle %0d", cyc);
    vals[0] = 2.0;
    run_batch(2, 1, 0, 0);

    vals[0] = 0.0; vals[1] = 0.0; vals[2] = 1.0;
    run_batch(3, 3, 0, 0);
    vals[0] = 0.0;
    run_batch(4, 1, 0, 0);

    for (int i = 0; i < 17; i++) vals[i] = 1.0;
    run_batch(5, 17, 0, 1);

    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(4, 1);
      for (int i = 0; i < n; i++) vals[i] = real'($urandom_range(7, 0));
      run_batch(6 + b, n, 2, $urandom_range(3, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
